// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latched IRQ/NMI pending, masking, priority select and INT/INA/Eoi handshake.
// Optional PRIORITY_ROTATE_EN: round-robin priority among maskable IRQs (fixed priority when undefined).
module interrupt_controller #(
   parameter int          NUM_IRQ       = 8,
   parameter int          ID_W          = 3,
   parameter logic [31:0] VECTOR_BASE   = 32'h8000_0180,
   parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010,
   parameter logic [31:0] NMI_VECTOR    = 32'h8000_0100
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [NUM_IRQ-1:0] IrqIn,
   input  logic               NmiIn,
   input  logic               MaskWr,
   input  logic [NUM_IRQ-1:0] MaskData,
   input  logic               INTD,
   input  logic               INA,
   input  logic               Eoi,
   output logic               INT,
   output logic               NMI,
   output logic [31:0]        IntVector,
   output logic [ID_W-1:0]    IntId,
   output logic [NUM_IRQ-1:0] Pending,
   output logic               InService
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_SVC  = 3'd2,
      ST_NREQ = 3'd3,
      ST_NSVC = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_IRQ-1:0] prev_q, pend_q, pend_d, mask_q, mask_d;
   logic [NUM_IRQ-1:0] ack_clr_s, req_vec_s;
   logic               nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_clr_s;
   logic               pre_q, pre_d;
   logic [ID_W-1:0]    id_q, id_d, sel_id_s, ptr_s, idx_s;
   logic               sel_found_s;
   logic               int_q, int_d, nmi_q, nmi_d, insvc_q, insvc_d;
   logic [31:0]        vec_q, vec_d;

   function automatic logic bit_at(input logic [NUM_IRQ-1:0] v, input logic [ID_W-1:0] i);
      logic [NUM_IRQ-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

`ifdef PRIORITY_ROTATE_EN
   logic [ID_W-1:0] ptr_q, ptr_d;

   // Round-robin pointer: search restarts just after the last acknowledged id
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_REQ && INA) begin
         ptr_d = (id_q == ID_W'(NUM_IRQ - 1)) ? '0 : id_q + ID_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr_s = ptr_q;
`else
   assign ptr_s = '0;
`endif

   assign req_vec_s = pend_q & ~mask_q;

   // First unmasked pending line, scanning upward from the priority pointer
   always_comb begin
      sel_found_s = 1'b0;
      sel_id_s    = '0;
      idx_s       = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         idx_s = ID_W'((int'(ptr_s) + k) % NUM_IRQ);
         if (!sel_found_s && bit_at(req_vec_s, idx_s)) begin
            sel_found_s = 1'b1;
            sel_id_s    = idx_s;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Handshake FSM: next state, ack clears and registered output values
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      pre_d     = pre_q;
      ack_clr_s = '0;
      nmi_clr_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (nmi_pend_q) begin
               state_d = ST_NREQ;
            end else if (sel_found_s && !INTD) begin
               state_d = ST_REQ;
               id_d    = sel_id_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (INA) begin
               state_d   = ST_SVC;
               ack_clr_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
            end else if (nmi_pend_q) begin
               state_d = ST_NREQ;
            end else if (INTD || bit_at(mask_q, id_q)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_SVC: begin
            if (Eoi) begin
               state_d = ST_IDLE;
            end else if (nmi_pend_q) begin
               state_d = ST_NREQ;
               pre_d   = 1'b1;
            end else begin
               state_d = ST_SVC;
            end
         end
         ST_NREQ: begin
            if (INA) begin
               state_d   = ST_NSVC;
               nmi_clr_s = 1'b1;
            end else begin
               state_d = ST_NREQ;
            end
         end
         ST_NSVC: begin
            if (Eoi) begin
               state_d = pre_q ? ST_SVC : ST_IDLE;
               pre_d   = 1'b0;
            end else begin
               state_d = ST_NSVC;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pre_d   = 1'b0;
         end
      endcase
   end

   // Pending/mask update (a new edge wins over the acknowledge clear) and output decode
   always_comb begin
      pend_d     = (pend_q & ~ack_clr_s) | (IrqIn & ~prev_q);
      nmi_pend_d = (nmi_pend_q & ~nmi_clr_s) | (NmiIn & ~nmi_prev_q);
      mask_d     = MaskWr ? MaskData : mask_q;
      int_d      = (state_d == ST_REQ);
      nmi_d      = (state_d == ST_NREQ);
      insvc_d    = (state_d == ST_SVC) || (state_d == ST_NSVC);
      case (state_d)
         ST_REQ, ST_SVC:   vec_d = VECTOR_BASE + 32'(id_d) * VECTOR_STRIDE;
         ST_NREQ, ST_NSVC: vec_d = NMI_VECTOR;
         default:          vec_d = 32'h0000_0000;
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         prev_q     <= '0;
         pend_q     <= '0;
         mask_q     <= '1;
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
         pre_q      <= 1'b0;
         id_q       <= '0;
         int_q      <= 1'b0;
         nmi_q      <= 1'b0;
         insvc_q    <= 1'b0;
         vec_q      <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         prev_q     <= IrqIn;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         nmi_prev_q <= NmiIn;
         nmi_pend_q <= nmi_pend_d;
         pre_q      <= pre_d;
         id_q       <= id_d;
         int_q      <= int_d;
         nmi_q      <= nmi_d;
         insvc_q    <= insvc_d;
         vec_q      <= vec_d;
      end
   end

   assign INT       = int_q;
   assign NMI       = nmi_q;
   assign IntVector = vec_q;
   assign IntId     = id_q;
   assign Pending   = pend_q;
   assign InService = insvc_q;

endmodule
